// File: rtl/conv_pkg.sv
// Shared definitions for the energy-source conversion scheduler:
// FSM state encoding, requester count and small helpers.
package conv_pkg;

    localparam int NSRC     = 4;
    localparam int SAMPLE_W = 8;
    localparam int IDX_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    // Round-robin pointer following a winner; wraps naturally in IDX_W bits.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] winner);
        return winner + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after
// ptr (wrapping) wins; outputs one-hot grant, its index and a valid flag.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand_s;

    // Scan requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        gnt    = 4'b0000;
        idx    = 2'd0;
        valid  = 1'b0;
        cand_s = ptr;
        for (int i = 0; i < 4; i++) begin
            cand_s = ptr + 2'(i);
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
                gnt   = 4'b0001 << cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/src_conv_scheduler.sv
// Shares a single converter among four energy-source requesters: round-robin
// grant, start pulse, bounded wait for the result, then a one-cycle publish.
module src_conv_scheduler #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int NSRC           = conv_pkg::NSRC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_req,
    input  logic [31:0] src_data,
    output logic [3:0]  grant,
    output logic        conv_start,
    output logic [7:0]  conv_din,
    input  logic        conv_done,
    input  logic [7:0]  conv_dout,
    output logic        res_valid,
    output logic [1:0]  res_src,
    output logic [7:0]  res_data,
    output logic        busy,
    output logic        timeout_err
);

    import conv_pkg::*;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r, state_nx;
    logic [1:0]  rr_ptr_r, rr_ptr_nx;
    logic [1:0]  owner_r, owner_nx;
    logic [7:0]  timer_r, timer_nx;
    logic [3:0]  grant_r, grant_nx;
    logic        conv_start_r, conv_start_nx;
    logic [7:0]  conv_din_r, conv_din_nx;
    logic        res_valid_r, res_valid_nx;
    logic [1:0]  res_src_r, res_src_nx;
    logic [7:0]  res_data_r, res_data_nx;
    logic        busy_r, busy_nx;
    logic        timeout_err_r, timeout_err_nx;

    logic [3:0]  arb_gnt_s;
    logic [1:0]  arb_idx_s;
    logic        arb_valid_s;
    logic [7:0]  sample_s;

    rr_arbiter4 u_arb (
        .req   (src_req),
        .ptr   (rr_ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    // Select the winning source's byte lane from the packed sample bus.
    always_comb begin
        sample_s = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            if (arb_idx_s == 2'(i)) begin
                sample_s = src_data[8*i +: 8];
            end else begin
                sample_s = sample_s;
            end
        end
    end

    // Next-state and next-output logic; every output is computed one edge early.
    always_comb begin
        state_nx       = state_r;
        rr_ptr_nx      = rr_ptr_r;
        owner_nx       = owner_r;
        timer_nx       = timer_r;
        grant_nx       = grant_r;
        conv_start_nx  = 1'b0;
        conv_din_nx    = conv_din_r;
        res_valid_nx   = 1'b0;
        res_src_nx     = res_src_r;
        res_data_nx    = res_data_r;
        timeout_err_nx = timeout_err_r;

        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_nx      = ST_ISSUE;
                    grant_nx      = arb_gnt_s;
                    owner_nx      = arb_idx_s;
                    rr_ptr_nx     = next_ptr(arb_idx_s);
                    conv_din_nx   = sample_s;
                    conv_start_nx = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT;
                timer_nx = 8'd0;
            end
            ST_WAIT: begin
                // A done on the last allowed WAIT cycle still wins over the timeout.
                if (conv_done) begin
                    state_nx     = ST_PUBLISH;
                    res_data_nx  = conv_dout;
                    res_src_nx   = owner_r;
                    res_valid_nx = 1'b1;
                end else if (timer_r == TMO_LAST) begin
                    state_nx       = ST_IDLE;
                    grant_nx       = 4'b0000;
                    timeout_err_nx = 1'b1;
                end else begin
                    timer_nx = timer_r + 8'd1;
                end
            end
            ST_PUBLISH: begin
                state_nx = ST_IDLE;
                grant_nx = 4'b0000;
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = 4'b0000;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rr_ptr_r      <= 2'd0;
            owner_r       <= 2'd0;
            timer_r       <= 8'd0;
            grant_r       <= 4'b0000;
            conv_start_r  <= 1'b0;
            conv_din_r    <= 8'h00;
            res_valid_r   <= 1'b0;
            res_src_r     <= 2'd0;
            res_data_r    <= 8'h00;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nx;
            rr_ptr_r      <= rr_ptr_nx;
            owner_r       <= owner_nx;
            timer_r       <= timer_nx;
            grant_r       <= grant_nx;
            conv_start_r  <= conv_start_nx;
            conv_din_r    <= conv_din_nx;
            res_valid_r   <= res_valid_nx;
            res_src_r     <= res_src_nx;
            res_data_r    <= res_data_nx;
            busy_r        <= busy_nx;
            timeout_err_r <= timeout_err_nx;
        end
    end

    assign grant       = grant_r;
    assign conv_start  = conv_start_r;
    assign conv_din    = conv_din_r;
    assign res_valid   = res_valid_r;
    assign res_src     = res_src_r;
    assign res_data    = res_data_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule
